clk_div_monitor: RTL

Downstream checker for the divided-clock output of the divide-by-N stage. It samples the divided clock in the source clk domain and produces one-cycle rise/fall strobes. It measures period and high time in clk cycles and declares lock after a run of correct periods. It flags faults: wrong period, wrong duty, or stuck clock. Sits between the divider and the consumers that use divided-clock strobes as clock enables.

---
 rtl/clk_div_mon_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 44 ++++
 rtl/clk_div_monitor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_div_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } mon_state_e;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_PERIOD = 2'b01;
  localparam logic [1:0] FC_DUTY   = 2'b10;
  localparam logic [1:0] FC_STUCK  = 2'b11;

  // A bad period with the right length can only be a duty problem
  // (wrong high time or a missing fall); otherwise it is a period error.
  function automatic logic [1:0] bad_code(input logic period_ok);
    return period_ok ? FC_DUTY : FC_PERIOD;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus edge detector producing registered one-cycle
// rise/fall strobes for an asynchronous (or glitchy) level input.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // synchronizer chain, bit 0 is the first flop after the pin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  // delay flop and registered strobes; strobes gated by the enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_dly  <= w_s;
      r_rise <= i_en &  w_s & ~r_dly;
      r_fall <= i_en & ~w_s &  r_dly;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: edge strobes, period/high-time measurement,
// lock detection and fault classification (period, duty, stuck).
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int DIV         = 6,
  parameter int HIGH        = 3,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_clr_fault,
  input  logic             i_div_clk,
  output logic             o_rise_pulse,
  output logic             o_fall_pulse,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_meas_valid,
  output logic             o_locked,
  output logic             o_fault,
  output logic [1:0]       o_fault_code
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam int               GC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [GC_W-1:0]  GC_LAST = GC_W'(LOCK_CNT - 1);

  mon_state_e       r_state, w_state_nxt;
  logic [GC_W-1:0]  r_gc, w_gc_nxt;
  logic [1:0]       r_code, w_code_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_fall_seen;
  logic             r_meas;
  logic             r_locked;
  logic             r_fault;

  logic w_strobe_en;
  logic w_rise;
  logic w_fall;
  logic w_chk;
  logic w_good;
  logic w_bad;
  logic w_timeout;
  logic w_cnt_clr;

  // strobes are suppressed while idle so a stale edge cannot arm us
  assign w_strobe_en = i_en && (r_state != IDLE);

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk   (clk),
    .rstn  (rstn),
    .i_en  (w_strobe_en),
    .i_d   (i_div_clk),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  // the arming rise (in ARM) only starts the counter and is never judged
  assign w_chk     = w_rise && (r_state == MEASURE || r_state == LOCKED ||
                                r_state == FAULT);
  assign w_good    = (r_cnt == DIV_C) && r_fall_seen && (r_high == HIGH_C);
  assign w_bad     = w_chk && !w_good;
  // a rise in the same cycle restarts the count, so it wins over timeout
  assign w_timeout = !w_rise && (r_cnt == TO_C) && (r_state != IDLE);
  // counter restarts from 0 on entry to ARM (out of IDLE or FAULT)
  assign w_cnt_clr = !i_en || (r_state == IDLE) ||
                     (r_state == FAULT && w_state_nxt == ARM);

  // next state, next good-period count and next fault code
  always_comb begin
    w_state_nxt = r_state;
    w_gc_nxt    = r_gc;
    w_code_nxt  = r_code;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_gc_nxt    = '0;
      w_code_nxt  = FC_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_gc_nxt    = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_state_nxt = MEASURE;
            w_gc_nxt    = '0;
          end else if (w_timeout) begin
            w_state_nxt = FAULT;
            w_code_nxt  = FC_STUCK;
          end
        end
        MEASURE: begin
          if (w_chk) begin
            if (w_good) begin
              if (r_gc == GC_LAST) begin
                w_state_nxt = LOCKED;
                w_gc_nxt    = '0;
              end else begin
                w_gc_nxt = r_gc + GC_W'(1);
              end
            end else begin
              w_gc_nxt = '0;
            end
          end else if (w_timeout) begin
            w_state_nxt = FAULT;
            w_code_nxt  = FC_STUCK;
          end
        end
        LOCKED: begin
          if (w_bad) begin
            w_state_nxt = FAULT;
            w_code_nxt  = bad_code(r_cnt == DIV_C);
          end else if (w_timeout) begin
            w_state_nxt = FAULT;
            w_code_nxt  = FC_STUCK;
          end
        end
        FAULT: begin
          // a fresh error alongside the clear keeps us in FAULT, code intact
          if (i_clr_fault && !w_bad && !w_timeout) begin
            w_state_nxt = ARM;
            w_code_nxt  = FC_NONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_gc_nxt    = '0;
          w_code_nxt  = FC_NONE;
        end
      endcase
    end
  end

  // state register with status outputs registered from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_gc     <= '0;
      r_code   <= FC_NONE;
      r_locked <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gc     <= w_gc_nxt;
      r_code   <= w_code_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      r_fault  <= (w_state_nxt == FAULT);
    end
  end

  // cycle counter: 1 after a rise, saturating, zero while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 r_cnt <= '0;
    else if (w_cnt_clr)        r_cnt <= '0;
    else if (w_rise)           r_cnt <= CNT_W'(1);
    else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  // capture period/high time; period/high time survive a disable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_period    <= '0;
      r_high      <= '0;
      r_fall_seen <= 1'b0;
      r_meas      <= 1'b0;
    end else begin
      r_meas <= i_en && w_chk;
      if (i_en && r_state != IDLE) begin
        if (w_rise) r_period <= r_cnt;
        if (w_fall) r_high   <= r_cnt;
      end
      if (!i_en || r_state == IDLE) r_fall_seen <= 1'b0;
      else if (w_rise)              r_fall_seen <= 1'b0;
      else if (w_fall)              r_fall_seen <= 1'b1;
    end
  end

  assign o_rise_pulse = w_rise;
  assign o_fall_pulse = w_fall;
  assign o_period     = r_period;
  assign o_high_time  = r_high;
  assign o_meas_valid = r_meas;
  assign o_locked     = r_locked;
  assign o_fault      = r_fault;
  assign o_fault_code = r_code;

endmodule
